// File: rtl/rx_pixel_packer.sv
// UART byte stream to RGB444 pixel strobes: finds the A5 5A frame header, unpacks
// 3 bytes into 2 pixels, counts W*H pixels and aborts on inter-byte timeout or mode exit.
module rx_pixel_packer #(
    parameter int W       = 50,
    parameter int H       = 40,
    parameter int TIMEOUT = 100000
) (
    input  logic        i_clk_sys,
    input  logic        i_rst_n,
    input  logic [7:0]  state,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        rx_valid,
    output logic [11:0] rx_data,
    output logic [14:0] pix_idx,
    output logic        frame_start,
    output logic        frame_done,
    output logic        frame_err
);

    localparam int NPIX = W * H;
    localparam int GW   = $clog2(TIMEOUT + 1);
    localparam logic [7:0]    RX_STATE = 8'h02;
    localparam logic [7:0]    HDR0     = 8'hA5;
    localparam logic [7:0]    HDR1     = 8'h5A;
    localparam logic [14:0]   LAST_PIX = 15'(NPIX - 1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(TIMEOUT);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    if ((NPIX % 2) != 0) begin : g_odd_pixels
        $error("rx_pixel_packer: W*H must be even");
    end
    if (NPIX > 32767) begin : g_too_many_pixels
        $error("rx_pixel_packer: W*H must fit in 15 bits");
    end

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC0  = 3'd1,
        ST_SYNC1  = 3'd2,
        ST_BYTE_A = 3'd3,
        ST_BYTE_B = 3'd4,
        ST_BYTE_C = 3'd5
    } st_t;

    st_t          st_q, st_d;
    logic [14:0]  pix_cnt_q, pix_cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]   a_q, a_d;
    logic [3:0]   r1_q, r1_d;
    logic         rx_valid_q, rx_valid_d;
    logic [11:0]  rx_data_q, rx_data_d;
    logic [14:0]  pix_idx_q, pix_idx_d;
    logic         start_q, start_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic         in_pix_s;
    logic         emit_s;
    logic [11:0]  pix_s;

    // Next-state, pixel assembly and pulse generation
    always_comb begin
        st_d       = st_q;
        pix_cnt_d  = pix_cnt_q;
        gap_d      = gap_q;
        a_d        = a_q;
        r1_d       = r1_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        pix_idx_d  = pix_idx_q;
        start_d    = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        emit_s     = 1'b0;
        pix_s      = 12'h000;
        in_pix_s   = (st_q == ST_BYTE_A) || (st_q == ST_BYTE_B) || (st_q == ST_BYTE_C);

        if (st_q == ST_IDLE) begin
            gap_d = '0;
            if (state == RX_STATE) begin
                st_d = ST_SYNC0;
            end else begin
                st_d = ST_IDLE;
            end
        end else if (state != RX_STATE) begin
            // Leaving receive mode drops any byte in this cycle; only a frame in progress is an error
            st_d  = ST_IDLE;
            gap_d = '0;
            err_d = in_pix_s;
        end else if (in_pix_s && (gap_q == GAP_MAX)) begin
            st_d  = ST_SYNC0;
            gap_d = '0;
            err_d = 1'b1;
        end else begin
            if (!in_pix_s || byte_valid) begin
                gap_d = '0;
            end else if (gap_q < GAP_MAX) begin
                gap_d = gap_q + GAP_ONE;
            end else begin
                gap_d = gap_q;
            end

            if (byte_valid) begin
                case (st_q)
                    ST_SYNC0: begin
                        if (byte_data == HDR0) begin
                            st_d = ST_SYNC1;
                        end else begin
                            st_d = ST_SYNC0;
                        end
                    end
                    ST_SYNC1: begin
                        if (byte_data == HDR1) begin
                            st_d      = ST_BYTE_A;
                            start_d   = 1'b1;
                            pix_cnt_d = 15'd0;
                        end else if (byte_data == HDR0) begin
                            st_d = ST_SYNC1;
                        end else begin
                            st_d = ST_SYNC0;
                        end
                    end
                    ST_BYTE_A: begin
                        a_d  = byte_data;
                        st_d = ST_BYTE_B;
                    end
                    ST_BYTE_B: begin
                        emit_s = 1'b1;
                        pix_s  = {a_q, byte_data[7:4]};
                        r1_d   = byte_data[3:0];
                        st_d   = ST_BYTE_C;
                    end
                    ST_BYTE_C: begin
                        emit_s = 1'b1;
                        pix_s  = {r1_q, byte_data};
                        st_d   = ST_BYTE_A;
                    end
                    default: begin
                        st_d = ST_IDLE;
                    end
                endcase
            end

            if (emit_s) begin
                rx_valid_d = 1'b1;
                rx_data_d  = pix_s;
                pix_idx_d  = pix_cnt_q;
                pix_cnt_d  = pix_cnt_q + 15'd1;
                if (pix_cnt_q == LAST_PIX) begin
                    done_d = 1'b1;
                    st_d   = ST_SYNC0;
                end else begin
                    done_d = 1'b0;
                end
            end
        end
    end

    // State and output registers
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st_q       <= ST_IDLE;
            pix_cnt_q  <= 15'd0;
            gap_q      <= '0;
            a_q        <= 8'h00;
            r1_q       <= 4'h0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 12'h000;
            pix_idx_q  <= 15'd0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            st_q       <= st_d;
            pix_cnt_q  <= pix_cnt_d;
            gap_q      <= gap_d;
            a_q        <= a_d;
            r1_q       <= r1_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            pix_idx_q  <= pix_idx_d;
            start_q    <= start_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign rx_valid    = rx_valid_q;
    assign rx_data     = rx_data_q;
    assign pix_idx     = pix_idx_q;
    assign frame_start = start_q;
    assign frame_done  = done_q;
    assign frame_err   = err_q;

endmodule

// File: tb/tb_rx_pixel_packer.sv
// Self-checking bench for rx_pixel_packer: random pixel data against a byte-stream
// reference model, covering header search, timeout, mode exit, back-to-back bytes and reset.
module tb_rx_pixel_packer;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int TO   = 20;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  state = 8'h00;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        rx_valid;
    logic [11:0] rx_data;
    logic [14:0] pix_idx;
    logic        frame_start;
    logic        frame_done;
    logic        frame_err;

    rx_pixel_packer #(.W(W), .H(H), .TIMEOUT(TO)) dut (
        .i_clk_sys   (clk),
        .i_rst_n     (rst_n),
        .state       (state),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .pix_idx     (pix_idx),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed side
    logic [26:0] obs_q[$];
    int n_start, n_done, n_err, done_idx, done_with_valid, err_cyc;

    always @(negedge clk) begin
        if (rx_valid) obs_q.push_back({pix_idx, rx_data});
        if (frame_start) n_start++;
        if (frame_done) begin
            n_done++;
            done_idx = int'(pix_idx);
            done_with_valid = int'(rx_valid);
        end
        if (frame_err) begin
            n_err++;
            err_cyc = cyc;
        end
    end

    // Reference model: pixels derived from the data bytes of the current frame
    logic [7:0]  dat_q[$];
    logic [26:0] exp_q[$];
    int fpix;
    int last_byte_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        obs_q.delete();
        exp_q.delete();
        n_start = 0; n_done = 0; n_err = 0;
        done_idx = -1; done_with_valid = 0; err_cyc = -1;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int n;
        logic [7:0] prev;
        dat_q.push_back(b);
        n = dat_q.size();
        if (n >= 2) prev = dat_q[n-2];
        else prev = 8'h00;
        if (fpix < NPIX) begin
            if ((n % 3) == 2) begin
                exp_q.push_back({15'(fpix), prev, b[7:4]});
                fpix++;
            end else if ((n % 3) == 0) begin
                exp_q.push_back({15'(fpix), prev[3:0], b});
                fpix++;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clk);
        #1;
        byte_valid = 1'b1;
        byte_data = b;
        last_byte_cyc = cyc;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_data(input logic [7:0] b);
        model_byte(b);
        send_byte(b, int'($urandom_range(0, 3)));
    endtask

    task automatic send_header();
        send_byte(8'hA5, 0);
        send_byte(8'h5A, 0);
        dat_q.delete();
        fpix = 0;
    endtask

    task automatic send_random(input int n);
        for (int i = 0; i < n; i++) send_data(8'($urandom));
    endtask

    task automatic compare_pixels(input string tag);
        int n;
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_pix%0d_data", tag, i), 32'(obs_q[i][11:0]), 32'(exp_q[i][11:0]));
            check($sformatf("%s_pix%0d_idx", tag, i), 32'(obs_q[i][26:12]), 32'(exp_q[i][26:12]));
        end
    endtask

    task automatic check_full_frame(input string tag);
        compare_pixels(tag);
        check({tag, "_start"}, 32'(n_start), 32'd1);
        check({tag, "_done"}, 32'(n_done), 32'd1);
        check({tag, "_done_idx"}, 32'(done_idx), 32'(NPIX - 1));
        check({tag, "_done_valid"}, 32'(done_with_valid), 32'd1);
        check({tag, "_err"}, 32'(n_err), 32'd0);
    endtask

    initial begin
        logic [7:0] t1 [12];
        t1 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h11, 8'h22, 8'h33, 8'h44};
        clear_all();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {1'b0, rx_valid, frame_start, frame_done, frame_err, rx_data, pix_idx}, 32'd0);
        rst_n = 1'b1;
        state = 8'h02;
        repeat (3) @(posedge clk);

        // 1: fixed frame
        clear_all();
        send_header();
        for (int i = 0; i < 12; i++) send_data(t1[i]);
        repeat (4) @(posedge clk);
        check_full_frame("t1");
        if (obs_q.size() >= 2) begin
            check("t1_first_pix", 32'(obs_q[0][11:0]), 32'h123);
            check("t1_second_pix", 32'(obs_q[1][11:0]), 32'h456);
        end else begin
            check("t1_two_pixels_seen", 32'(obs_q.size()), 32'd2);
        end

        // 2: noise and repeated A5 before header
        clear_all();
        send_byte(8'h00, 0);
        send_byte(8'hA5, 0);
        send_header();
        send_random(12);
        repeat (4) @(posedge clk);
        check_full_frame("t2");

        // 3: timeout mid-frame, then a fresh frame restarts indexing
        clear_all();
        send_header();
        send_random(4);
        repeat (TO + 10) @(posedge clk);
        compare_pixels("t3_partial");
        check("t3_err", 32'(n_err), 32'd1);
        check("t3_err_timing", 32'(err_cyc - last_byte_cyc), 32'(TO + 2));
        check("t3_no_done", 32'(n_done), 32'd0);
        clear_all();
        send_header();
        send_random(12);
        repeat (4) @(posedge clk);
        check_full_frame("t3_next");

        // 4: leave receive mode mid-frame
        clear_all();
        send_header();
        send_random(6);
        @(posedge clk);
        #1;
        state = 8'h03;
        repeat (3) @(posedge clk);
        send_byte(8'h77, 0);
        repeat (3) @(posedge clk);
        compare_pixels("t4_partial");
        check("t4_err", 32'(n_err), 32'd1);
        #1;
        state = 8'h02;
        repeat (3) @(posedge clk);
        clear_all();
        send_header();
        send_random(12);
        repeat (4) @(posedge clk);
        check_full_frame("t4_next");

        // 5: back-to-back bytes
        clear_all();
        send_header();
        @(posedge clk);
        #1;
        byte_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            byte_data = 8'($urandom);
            model_byte(byte_data);
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;
        repeat (4) @(posedge clk);
        check_full_frame("t5");

        // 6: asynchronous reset mid-frame
        clear_all();
        send_header();
        for (int i = 0; i < 5; i++) begin
            model_byte(t1[i]);
            send_byte(t1[i], 0);
        end
        repeat (3) @(posedge clk);
        compare_pixels("t6_before");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_reset", {1'b0, rx_valid, frame_start, frame_done, frame_err, rx_data, pix_idx}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        clear_all();
        for (int i = 0; i < 12; i++) send_byte(8'(8'h11 * (i % 8 + 1)), 0);
        repeat (4) @(posedge clk);
        check("t6_no_pixels", 32'(obs_q.size()), 32'd0);
        check("t6_no_start", 32'(n_start), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
